pwm_dac: RTL and testbench
==========================

// Module: pwm_dac
// PURPOSE
//  Output stage downstream of the sine generator. Converts its D_WIDTH-bit sample stream into a
//  single-bit PWM waveform (one sample per PWM period) for an RC-filtered pin or LED.
//  Paces the generator: sample_req drives the generator's en, one pulse per PWM period.
//  Double-buffers the captured sample so duty changes only on period boundaries (glitch-free).
// PARAMETERS
//  D_WIDTH     8  sample / duty width; PWM period = 2**D_WIDTH-1 ticks
//  PRESC_WIDTH 8  width of prescaler reload input
//  SAMPLE_LAT  2  cycles from sample_req to valid data_in (counter edge + sync ROM edge)
// PORTS
//  clk          input  1            system clock, all state on rising edge
//  rst          input  1            asynchronous, active-low reset
//  en           input  1            1 = run; 0 = return to IDLE on next edge
//  presc        input  PRESC_WIDTH  PWM tick every presc+1 clk cycles
//  data_in      input  D_WIDTH      sample from sine generator (its data output)
//  sample_req   output 1            1-cycle pulse requesting next sample (to generator en)
//  pwm_out      output 1            PWM waveform
//  period_start output 1            1-cycle pulse, first cycle of each PWM period
//  duty_out     output D_WIDTH      duty currently being modulated
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; presc_cnt, pwm_cnt, lat_cnt, duty, next_duty = 0;
//   all outputs 0. Outputs stay 0 while rst=0.
//  FSM IDLE -> PRIME -> RUN; en=0 in any state -> IDLE on next edge (pending capture dropped,
//   counters and duty cleared, pwm_out=0). sample_req never asserted in IDLE.
//  IDLE: en=1 at edge -> PRIME, sample_req=1 for the following cycle, lat_cnt=0.
//  PRIME: lat_cnt counts cycles after the req cycle; data_in sampled at the edge ending
//   cycle req+SAMPLE_LAT: duty<=data_in, presc_cnt=0, pwm_cnt=0, state->RUN.
//  RUN: tick when presc_cnt>=presc (>= so a lowered presc cannot run away); on tick
//   presc_cnt=0, else presc_cnt+1. On tick pwm_cnt increments, wrapping 2**D_WIDTH-2 -> 0.
//  period_start=1 in RUN when pwm_cnt==0 && presc_cnt==0; sample_req=period_start in RUN.
//  Each RUN sample_req: next_duty<=data_in at edge ending cycle req+SAMPLE_LAT.
//  duty<=next_duty on the tick that wraps pwm_cnt to 0; never mid-period.
//  pwm_out = (state==RUN) && (pwm_cnt < duty), from registered values only.
//   duty=0 -> constant 0; duty=2**D_WIDTH-1 -> constant 1 (period is 2**D_WIDTH-1 ticks).
//  Period = (2**D_WIDTH-1)*(presc+1) cycles; exactly one sample_req per period.
//  presc is live: change takes effect on the next compare, no restart.
//  Constraint: SAMPLE_LAT < 2**D_WIDTH-1, so each capture completes inside its period.
//  duty_out = duty.
// TESTING
//  1 rst=0 mid-RUN with pwm_out=1 -> pwm_out, sample_req, period_start, duty_out drop to 0
//    without a clock edge; release with en=1 -> PRIME, first sample_req next cycle.
//  2 presc=0, data_in=128 held, en=1 -> first capture 2 cycles after sample_req;
//    pwm_out high 128 of every 255 cycles; sample_req every 255 cycles.
//  3 data_in=0 then 255 -> pwm_out never high for a full period, then never low
//    across two consecutive period boundaries.
//  4 presc=3; data_in 64 -> 192 mid-period -> duty_out updates only at the wrap;
//    period_start spacing = 1020 cycles.
//  5 en=0 mid-period -> IDLE next edge, pwm_out=0, no sample_req;
//    en=1 again -> fresh PRIME with new sample_req.
//  6 Integrated with sine generator (incr=1): successive duty_out values equal
//    consecutive sine ROM entries, none skipped or repeated.

Source files
------------

// File: rtl/pwm_dac.sv
// PWM output stage for the sine generator: paces the generator with one sample request per
// PWM period and double-buffers each captured sample so the duty only changes on a period wrap.
module pwm_dac #(
    parameter int D_WIDTH     = 8,
    parameter int PRESC_WIDTH = 8,
    parameter int SAMPLE_LAT  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic [D_WIDTH-1:0]     data_in,
    output logic                   sample_req,
    output logic                   pwm_out,
    output logic                   period_start,
    output logic [D_WIDTH-1:0]     duty_out
);

    localparam int                 LAT_W    = $clog2(SAMPLE_LAT + 2);
    localparam logic [LAT_W-1:0]   LAT_LAST = LAT_W'(SAMPLE_LAT);
    // Last PWM count is 2**D_WIDTH-2, so a full-scale duty keeps the output high all period.
    localparam logic [D_WIDTH-1:0] PWM_LAST = {{(D_WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [PRESC_WIDTH-1:0] presc_cnt_r;
    logic [D_WIDTH-1:0]     pwm_cnt_r;
    logic [LAT_W-1:0]       lat_cnt_r;
    logic                   pend_r;
    logic [D_WIDTH-1:0]     duty_r;
    logic [D_WIDTH-1:0]     next_duty_r;

    logic                   sample_req_s;
    logic                   period_start_s;
    logic                   pwm_on_s;
    logic                   tick_s;
    logic [LAT_W-1:0]       lat_now_s;
    logic                   run_cap_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_nxt_s    = state_r;
        sample_req_s   = 1'b0;
        period_start_s = 1'b0;
        pwm_on_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (en) begin
                    state_nxt_s = PRIME;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRIME: begin
                sample_req_s = (lat_cnt_r == {LAT_W{1'b0}});
                if (!en) begin
                    state_nxt_s = IDLE;
                end else if (lat_cnt_r == LAT_LAST) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PRIME;
                end
            end
            RUN: begin
                period_start_s = (pwm_cnt_r == {D_WIDTH{1'b0}}) &&
                                 (presc_cnt_r == {PRESC_WIDTH{1'b0}});
                sample_req_s   = period_start_s;
                pwm_on_s       = (pwm_cnt_r < duty_r);
                if (!en) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Prescaler tick and capture-latency tracking for requests issued in RUN
    always_comb begin
        tick_s = (presc_cnt_r >= presc);
        if (sample_req_s) begin
            lat_now_s = {LAT_W{1'b0}};
        end else begin
            lat_now_s = lat_cnt_r;
        end
        run_cap_s = (sample_req_s || pend_r) && (lat_now_s == LAT_LAST);
    end

    // Counters, sample capture and duty double-buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_cnt_r <= {PRESC_WIDTH{1'b0}};
            pwm_cnt_r   <= {D_WIDTH{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            pend_r      <= 1'b0;
            duty_r      <= {D_WIDTH{1'b0}};
            next_duty_r <= {D_WIDTH{1'b0}};
        end else if (!en || (state_r == IDLE)) begin
            presc_cnt_r <= {PRESC_WIDTH{1'b0}};
            pwm_cnt_r   <= {D_WIDTH{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            pend_r      <= 1'b0;
            duty_r      <= {D_WIDTH{1'b0}};
            next_duty_r <= {D_WIDTH{1'b0}};
        end else if (state_r == PRIME) begin
            if (lat_cnt_r == LAT_LAST) begin
                duty_r      <= data_in;
                presc_cnt_r <= {PRESC_WIDTH{1'b0}};
                pwm_cnt_r   <= {D_WIDTH{1'b0}};
                lat_cnt_r   <= {LAT_W{1'b0}};
                pend_r      <= 1'b0;
            end else begin
                lat_cnt_r <= lat_cnt_r + LAT_W'(1);
            end
        end else if (state_r == RUN) begin
            if (tick_s) begin
                presc_cnt_r <= {PRESC_WIDTH{1'b0}};
                if (pwm_cnt_r == PWM_LAST) begin
                    pwm_cnt_r <= {D_WIDTH{1'b0}};
                    duty_r    <= next_duty_r;
                end else begin
                    pwm_cnt_r <= pwm_cnt_r + D_WIDTH'(1);
                end
            end else begin
                presc_cnt_r <= presc_cnt_r + PRESC_WIDTH'(1);
            end
            // The capture always lands well before the wrap, so next_duty never races duty.
            if (run_cap_s) begin
                next_duty_r <= data_in;
                pend_r      <= 1'b0;
                lat_cnt_r   <= {LAT_W{1'b0}};
            end else if (sample_req_s || pend_r) begin
                pend_r    <= 1'b1;
                lat_cnt_r <= lat_now_s + LAT_W'(1);
            end else begin
                pend_r <= pend_r;
            end
        end else begin
            presc_cnt_r <= {PRESC_WIDTH{1'b0}};
            pwm_cnt_r   <= {D_WIDTH{1'b0}};
            lat_cnt_r   <= {LAT_W{1'b0}};
            pend_r      <= 1'b0;
            duty_r      <= {D_WIDTH{1'b0}};
            next_duty_r <= {D_WIDTH{1'b0}};
        end
    end

    assign sample_req   = sample_req_s;
    assign period_start = period_start_s;
    assign pwm_out      = pwm_on_s;
    assign duty_out     = duty_r;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: a table of steady-duty vectors plus hand-written sequences
// for reset, latency, duty double-buffering, enable drop and a modelled sine generator.
module tb_pwm_dac;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] presc;
    logic [7:0] data_drv;
    logic       use_gen;
    logic [7:0] data_in;
    logic       sample_req;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_out;

    logic [7:0] gen_addr;
    logic [7:0] gen_q;

    int n_cmp;
    int n_bad;

    typedef struct {
        int presc;
        int data;
        int len;
        int hi;
    } vec_t;

    vec_t vecs[7];

    pwm_dac #(.D_WIDTH(8), .PRESC_WIDTH(8), .SAMPLE_LAT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .presc        (presc),
        .data_in      (data_in),
        .sample_req   (sample_req),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_out     (duty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [7:0] a);
        return 8'((a * 37) + 11);
    endfunction

    // Generator model: address counter advanced by sample_req, synchronous ROM read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gen_addr <= 8'd0;
            gen_q    <= 8'd0;
        end else begin
            if (sample_req) gen_addr <= gen_addr + 8'd1;
            gen_q <= rom_f(gen_addr);
        end
    end

    assign data_in = use_gen ? gen_q : data_drv;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_ps(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (period_start) seen = 1'b1;
        end
        check(name, int'(seen), 1);
    endtask

    // Called on a negedge where period_start is high; returns on the next one.
    task automatic measure(input int exp_duty, output int len, output int hi,
                           output int reqs, output int dbad);
        len = 0; hi = 0; reqs = 0; dbad = 0;
        do begin
            if (pwm_out) hi++;
            if (sample_req) reqs++;
            if (int'(duty_out) != exp_duty) dbad++;
            len++;
            @(negedge clk);
        end while (!period_start && len < 5000);
    endtask

    initial begin
        int len, hi, reqs, dbad, lows;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0; en = 1'b0; presc = 8'd0; data_drv = 8'd0; use_gen = 1'b0;

        vecs[0] = '{presc: 0, data: 128, len: 255,  hi: 128};
        vecs[1] = '{presc: 0, data: 0,   len: 255,  hi: 0};
        vecs[2] = '{presc: 0, data: 255, len: 255,  hi: 255};
        vecs[3] = '{presc: 1, data: 1,   len: 510,  hi: 2};
        vecs[4] = '{presc: 3, data: 64,  len: 1020, hi: 256};
        vecs[5] = '{presc: 0, data: 254, len: 255,  hi: 254};
        vecs[6] = '{presc: 2, data: 100, len: 765,  hi: 300};

        repeat (2) @(negedge clk);
        check("rst_pwm", pwm_out, 0);
        check("rst_req", sample_req, 0);
        check("rst_ps", period_start, 0);
        check("rst_duty", duty_out, 0);
        rst = 1'b1;

        for (int v = 0; v < 7; v++) begin
            do_reset();
            presc    = 8'(vecs[v].presc);
            data_drv = 8'(vecs[v].data);
            en       = 1'b1;
            wait_ps($sformatf("v%0d_start", v), 20);
            check($sformatf("v%0d_duty", v), duty_out, vecs[v].data);
            measure(vecs[v].data, len, hi, reqs, dbad);
            check($sformatf("v%0d_len1", v), len, vecs[v].len);
            check($sformatf("v%0d_hi1", v), hi, vecs[v].hi);
            check($sformatf("v%0d_req1", v), reqs, 1);
            measure(vecs[v].data, len, hi, reqs, dbad);
            check($sformatf("v%0d_len2", v), len, vecs[v].len);
            check($sformatf("v%0d_hi2", v), hi, vecs[v].hi);
            check($sformatf("v%0d_dstable", v), dbad, 0);
        end

        // Async reset mid-RUN, then restart and check the two-cycle capture latency.
        do_reset();
        presc = 8'd0; data_drv = 8'd200; en = 1'b1;
        wait_ps("c1_start", 20);
        repeat (10) @(negedge clk);
        check("c1_pwm_hi", pwm_out, 1);
        #2 rst = 1'b0;
        #1;
        check("c1_async_pwm", pwm_out, 0);
        check("c1_async_req", sample_req, 0);
        check("c1_async_ps", period_start, 0);
        check("c1_async_duty", duty_out, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("c1_req", sample_req, 1);
        data_drv = 8'd11;
        @(negedge clk);
        check("c1_req_once", sample_req, 0);
        data_drv = 8'd22;
        @(negedge clk);
        check("c1_duty_pre", duty_out, 0);
        check("c1_ps_pre", period_start, 0);
        data_drv = 8'd33;
        @(negedge clk);
        check("c1_ps", period_start, 1);
        check("c1_latency_duty", duty_out, 33);
        data_drv = 8'd44;

        // Duty 0 for a full period, then 255 across two period boundaries.
        do_reset();
        presc = 8'd0; data_drv = 8'd0; en = 1'b1;
        wait_ps("c3_start", 20);
        data_drv = 8'd255;
        measure(0, len, hi, reqs, dbad);
        check("c3_zero_hi", hi, 0);
        measure(255, len, hi, reqs, dbad);
        check("c3_full_hi", hi, 255);
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            if (!pwm_out) lows++;
            @(negedge clk);
        end
        check("c3_full_boundary", lows, 0);

        // Mid-period data change with presc=3: duty follows only at the wrap.
        do_reset();
        presc = 8'd3; data_drv = 8'd64; en = 1'b1;
        wait_ps("c4_start", 20);
        @(negedge clk);
        data_drv = 8'd192;
        measure(64, len, hi, reqs, dbad);
        check("c4_len1", len + 1, 1020);
        check("c4_hold64", dbad, 0);
        check("c4_new_duty", duty_out, 192);
        measure(192, len, hi, reqs, dbad);
        check("c4_len2", len, 1020);
        check("c4_hi2", hi, 768);
        check("c4_hold192", dbad, 0);

        // Enable dropped mid-period, then re-enabled.
        do_reset();
        presc = 8'd0; data_drv = 8'd100; en = 1'b1;
        wait_ps("c5_start", 20);
        repeat (20) @(negedge clk);
        check("c5_pwm_hi", pwm_out, 1);
        en = 1'b0;
        @(negedge clk);
        check("c5_pwm_off", pwm_out, 0);
        check("c5_duty_off", duty_out, 0);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            if (sample_req || period_start) reqs++;
            @(negedge clk);
        end
        check("c5_idle_quiet", reqs, 0);
        en = 1'b1;
        @(negedge clk);
        check("c5_reprime_req", sample_req, 1);
        wait_ps("c5_restart", 20);
        check("c5_duty", duty_out, 100);

        // Paced generator: each period takes the next ROM entry.
        do_reset();
        use_gen = 1'b1; presc = 8'd0; en = 1'b1;
        wait_ps("c6_start", 20);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("c6_duty%0d", k), duty_out, int'(rom_f(8'(k))));
            measure(int'(rom_f(8'(k))), len, hi, reqs, dbad);
            check($sformatf("c6_hi%0d", k), hi, int'(rom_f(8'(k))));
            check($sformatf("c6_stable%0d", k), dbad, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
